// File: rtl/audio_voice_mix_scheduler.sv
// ============================================================================
// Module   : audio_voice_mix_scheduler
// Purpose  : Polls voice sources once per frame, sums and saturates their
//            samples, and writes one left-justified sample to the DAC FIFO.
//            Optional macro MIX_LINE_IN_EN seeds separate L/R accumulators
//            with the line-in sample.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_voice_mix_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = 16,
   parameter int OUT_W      = 32
) (
   input  logic                           CLOCK_50,
   input  logic                           reset,
   input  logic [NUM_VOICES-1:0]          voice_valid,
   input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_data,
   output logic [NUM_VOICES-1:0]          voice_ready,
   input  logic [NUM_VOICES-1:0]          voice_mute,
   input  logic                           status_clr,
   input  logic                           audio_out_allowed,
   output logic [OUT_W-1:0]               left_channel_audio_out,
   output logic [OUT_W-1:0]               right_channel_audio_out,
   output logic                           write_audio_out,
   input  logic                           audio_in_available,
   input  logic [OUT_W-1:0]               left_channel_audio_in,
   input  logic [OUT_W-1:0]               right_channel_audio_in,
   output logic                           read_audio_in,
   output logic                           busy,
   output logic                           clip,
   output logic [NUM_VOICES-1:0]          underrun
);

   localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
   localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic signed [ACC_W-1:0] c_sat_max =
      {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] c_sat_min =
      {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_SAT     = 3'd2,
      S_WRITE   = 3'd3,
      S_GAP     = 3'd4
   } state_t;

   state_t                   r_state, w_state_next;
   logic [SLOT_W-1:0]        r_slot;
   logic signed [ACC_W-1:0]  r_acc_l;
   logic [OUT_W-1:0]         r_left_out;
   logic                     w_start;
   logic [SAMPLE_W-1:0]      w_sample;
   logic signed [ACC_W-1:0]  w_add;
   logic [SAMPLE_W:0]        w_sat_l;
   logic                     w_clip_set;
   logic [NUM_VOICES-1:0]    w_underrun_set;
   logic                     w_unused_in;

   // MSB of the result flags that clamping took place.
   function automatic logic [SAMPLE_W:0] saturate(input logic signed [ACC_W-1:0] a);
      if (a > c_sat_max)
         return {1'b1, c_sat_max[SAMPLE_W-1:0]};
      else if (a < c_sat_min)
         return {1'b1, c_sat_min[SAMPLE_W-1:0]};
      else
         return {1'b0, a[SAMPLE_W-1:0]};
   endfunction

   assign w_unused_in = &{1'b0, audio_in_available, left_channel_audio_in,
                          right_channel_audio_in};

   assign w_sample = voice_data[int'(r_slot)*SAMPLE_W +: SAMPLE_W];
   assign w_add    = (voice_valid[r_slot] && !voice_mute[r_slot]) ?
                     ACC_W'($signed(w_sample)) : '0;
   assign w_sat_l  = saturate(r_acc_l);

`ifdef MIX_LINE_IN_EN
   logic signed [ACC_W-1:0] r_acc_r;
   logic [OUT_W-1:0]        r_right_out;
   logic [SAMPLE_W:0]       w_sat_r;

   assign w_start    = audio_out_allowed & audio_in_available;
   assign w_sat_r    = saturate(r_acc_r);
   assign w_clip_set = (r_state == S_SAT) & (w_sat_l[SAMPLE_W] | w_sat_r[SAMPLE_W]);
   assign right_channel_audio_out = r_right_out;
   assign read_audio_in           = (r_state == S_WRITE);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_acc_r     <= '0;
         r_right_out <= '0;
      end else begin
         if (r_state == S_IDLE && w_start)
            r_acc_r <= ACC_W'($signed(right_channel_audio_in[OUT_W-1 -: SAMPLE_W]));
         else if (r_state == S_COLLECT)
            r_acc_r <= r_acc_r + w_add;
         if (r_state == S_SAT)
            r_right_out <= OUT_W'(w_sat_r[SAMPLE_W-1:0]) << (OUT_W - SAMPLE_W);
      end
   end
`else
   assign w_start    = audio_out_allowed;
   assign w_clip_set = (r_state == S_SAT) & w_sat_l[SAMPLE_W];
   assign right_channel_audio_out = r_left_out;
   assign read_audio_in           = 1'b0;
`endif

   assign left_channel_audio_out = r_left_out;
   assign write_audio_out        = (r_state == S_WRITE);
   assign busy                   = (r_state != S_IDLE);

   always_ff @(posedge CLOCK_50) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next   = r_state;
      voice_ready    = '0;
      w_underrun_set = '0;
      case (r_state)
         S_IDLE:    if (w_start) w_state_next = S_COLLECT;
         S_COLLECT: begin
            if (voice_valid[r_slot])
               voice_ready[r_slot] = 1'b1;
            else
               w_underrun_set[r_slot] = 1'b1;
            if (r_slot == SLOT_W'(NUM_VOICES-1))
               w_state_next = S_SAT;
         end
         S_SAT:     w_state_next = S_WRITE;
         S_WRITE:   w_state_next = S_GAP;
         S_GAP:     w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_slot     <= '0;
         r_acc_l    <= '0;
         r_left_out <= '0;
         clip       <= 1'b0;
         underrun   <= '0;
      end else begin
         // A new set event takes priority over a simultaneous clear.
         clip     <= (status_clr ? 1'b0 : clip) | w_clip_set;
         underrun <= (status_clr ? '0 : underrun) | w_underrun_set;
         case (r_state)
            S_IDLE: if (w_start) begin
               r_slot <= '0;
`ifdef MIX_LINE_IN_EN
               r_acc_l <= ACC_W'($signed(left_channel_audio_in[OUT_W-1 -: SAMPLE_W]));
`else
               r_acc_l <= '0;
`endif
            end
            S_COLLECT: begin
               r_acc_l <= r_acc_l + w_add;
               r_slot  <= r_slot + 1'b1;
            end
            S_SAT: r_left_out <= OUT_W'(w_sat_l[SAMPLE_W-1:0]) << (OUT_W - SAMPLE_W);
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_audio_voice_mix_scheduler.sv
// ============================================================================
// Module   : tb_audio_voice_mix_scheduler
// Purpose  : Directed scoreboard bench for audio_voice_mix_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_voice_mix_scheduler;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  voice_valid = '0;
   logic [63:0] voice_data = '0;
   logic [3:0]  voice_ready;
   logic [3:0]  voice_mute = '0;
   logic        status_clr = 1'b0;
   logic        audio_out_allowed = 1'b0;
   logic [31:0] left_channel_audio_out, right_channel_audio_out;
   logic        write_audio_out;
   logic        audio_in_available = 1'b0;
   logic [31:0] left_channel_audio_in = '0, right_channel_audio_in = '0;
   logic        read_audio_in, busy, clip;
   logic [3:0]  underrun;

   typedef struct {logic [31:0] l; logic [31:0] r;} exp_t;
   exp_t q[$];
   int errors = 0;
   int checks = 0;

`ifdef MIX_LINE_IN_EN
   localparam logic c_exp_rd = 1'b1;
`else
   localparam logic c_exp_rd = 1'b0;
`endif

   audio_voice_mix_scheduler dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .voice_valid(voice_valid),
      .voice_data(voice_data), .voice_ready(voice_ready), .voice_mute(voice_mute),
      .status_clr(status_clr), .audio_out_allowed(audio_out_allowed),
      .left_channel_audio_out(left_channel_audio_out),
      .right_channel_audio_out(right_channel_audio_out),
      .write_audio_out(write_audio_out), .audio_in_available(audio_in_available),
      .left_channel_audio_in(left_channel_audio_in),
      .right_channel_audio_in(right_channel_audio_in),
      .read_audio_in(read_audio_in), .busy(busy), .clip(clip), .underrun(underrun));

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe is matched against the oldest expected frame.
   always @(negedge CLOCK_50) begin
      if (write_audio_out) begin
         if (q.size() == 0) begin
            chk("unexpected_write", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("left_out", {32'd0, left_channel_audio_out}, {32'd0, e.l});
            chk("right_out", {32'd0, right_channel_audio_out}, {32'd0, e.r});
            chk("read_audio_in", {63'd0, read_audio_in}, {63'd0, c_exp_rd});
         end
      end
   end

   task automatic run_frame(input logic [15:0] d0, d1, d2, d3,
                            input logic [3:0] valid, mute,
                            input logic [31:0] el, er);
      exp_t e;
      @(negedge CLOCK_50);
      voice_data        = {d3, d2, d1, d0};
      voice_valid       = valid;
      voice_mute        = mute;
      audio_out_allowed = 1'b1;
      e.l = el;
      e.r = er;
      q.push_back(e);
      @(posedge CLOCK_50);
      #1 audio_out_allowed = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLOCK_50);
         chk("voice_ready_slot", {60'd0, voice_ready}, valid[k] ? 64'd1 << k : 64'd0);
         chk("busy_collect", {63'd0, busy}, 64'd1);
      end
      @(negedge CLOCK_50);
      chk("no_write_in_sat", {62'd0, write_audio_out, |voice_ready}, 64'd0);
      @(negedge CLOCK_50);
      chk("write_latency", {63'd0, write_audio_out}, 64'd1);
      @(negedge CLOCK_50);
      chk("gap_state", {62'd0, write_audio_out, busy}, 64'd1);
      @(negedge CLOCK_50);
      chk("idle_after_gap", {63'd0, busy}, 64'd0);
   endtask

   task automatic clear_status();
      @(negedge CLOCK_50);
      status_clr = 1'b1;
      @(negedge CLOCK_50);
      status_clr = 1'b0;
   endtask

   initial begin
      // Reset with toggling inputs
      for (int i = 0; i < 3; i++) begin
         @(negedge CLOCK_50);
         voice_valid = 4'($urandom); voice_mute = 4'($urandom);
         voice_data = {$urandom, $urandom}; audio_out_allowed = 1'($urandom);
         status_clr = 1'($urandom); audio_in_available = 1'($urandom);
         @(negedge CLOCK_50);
         chk("reset_outputs", {left_channel_audio_out, 32'd0} | {32'd0, right_channel_audio_out}
             | {51'd0, voice_ready, underrun, clip, busy, write_audio_out, read_audio_in}, 64'd0);
      end
      @(negedge CLOCK_50);
      reset = 1'b0; voice_valid = '0; voice_mute = '0; voice_data = '0;
      audio_out_allowed = 1'b0; status_clr = 1'b0; audio_in_available = 1'b1;

      // Basic mix: 1000 + 2000 - 500 + 0 = 2500
      run_frame(16'd1000, 16'd2000, -16'sd500, 16'd0, 4'b1111, 4'b0000,
                32'h09C4_0000, 32'h09C4_0000);
      chk("clip_after_basic", {63'd0, clip}, 64'd0);
      chk("underrun_after_basic", {60'd0, underrun}, 64'd0);

      // Positive and negative saturation
      run_frame(16'd16000, 16'd16000, 16'd16000, 16'd16000, 4'b1111, 4'b0000,
                32'h7FFF_0000, 32'h7FFF_0000);
      chk("clip_positive", {63'd0, clip}, 64'd1);
      run_frame(16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'b1111, 4'b0000,
                32'h8000_0000, 32'h8000_0000);
      chk("clip_negative", {63'd0, clip}, 64'd1);
      clear_status();
      chk("clip_cleared", {63'd0, clip}, 64'd0);

      // Underrun on voice 2
      run_frame(16'd100, 16'd100, 16'd100, 16'd100, 4'b1011, 4'b0000,
                32'h012C_0000, 32'h012C_0000);
      chk("underrun_voice2", {60'd0, underrun}, 64'd4);
      clear_status();
      chk("underrun_cleared", {60'd0, underrun}, 64'd0);

      // Muted voice is consumed but contributes nothing
      run_frame(16'd1000, 16'd0, 16'd0, 16'd0, 4'b1111, 4'b0001, 32'd0, 32'd0);
      chk("clip_after_mute", {63'd0, clip}, 64'd0);

      // Reset in collect slot 1 discards the frame
      @(negedge CLOCK_50);
      voice_data = {16'd7, 16'd5000, 16'd3000, 16'd1000};
      voice_valid = 4'b1111; audio_out_allowed = 1'b1;
      @(posedge CLOCK_50);
      #1 audio_out_allowed = 1'b0;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("slot1_ready", {60'd0, voice_ready}, 64'd2);
      reset = 1'b1;
      @(negedge CLOCK_50);
      chk("busy_after_reset", {63'd0, busy}, 64'd0);
      chk("outputs_after_reset", {left_channel_audio_out, right_channel_audio_out}, 64'd0);
      reset = 1'b0;
      repeat (8) @(negedge CLOCK_50);
      run_frame(16'd1000, 16'd2000, -16'sd500, 16'd0, 4'b1111, 4'b0000,
                32'h09C4_0000, 32'h09C4_0000);

`ifdef MIX_LINE_IN_EN
      // Line-in seeds left accumulator only
      left_channel_audio_in = 32'h0001_0000;
      right_channel_audio_in = 32'h0;
      run_frame(16'd0, 16'd0, 16'd0, 16'd0, 4'b1111, 4'b0000, 32'h0001_0000, 32'h0);
      left_channel_audio_in = '0;
`endif

      repeat (4) @(negedge CLOCK_50);
      chk("scoreboard_empty", 64'(q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
